serial_right_shifter: RTL and testbench
=======================================

Name: serial_right_shifter

Overview:
- Multi-cycle right shifter for the 16-bit datapath; the right-direction counterpart of the existing left one-bit shifter.
- Shifts the operand right one bit per clock under a start/done handshake, in logical or arithmetic mode.
- Produces the result plus carry-out and zero flags for the ALU/flag logic.
- Sits beside the ALU. Control holds the instruction until done.

Parameters:
- WIDTH, 16, operand/result width in bits.
- AMT_W, 4, shift-amount width; maximum shift is 2^AMT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset: asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- to_shift  input  WIDTH  operand; captured on the accepted start edge.
- amount  input  AMT_W  shift count; captured with to_shift.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate (see Optional Feature), 11 treated as logical.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse; result/flags valid.
- shifted  output  WIDTH  result register.
- carry_out  output  1  last bit shifted out.
- zero  output  1  shifted == 0.

Behaviour:
- States:
  - IDLE: start=1 captures to_shift, amount and mode; count<=amount. Next state is SHIFT if amount!=0, else DONE. start=0 stays in IDLE.
  - SHIFT: each edge shifts the working register right by 1 and decrements count. When count==1 on the edge, next state is DONE.
  - DONE: done=1 for exactly this cycle; unconditional return to IDLE.
- Latency: done is high in the cycle after amount+1 edges following the accepting edge (amount=0 gives 1 edge; amount=15 gives 16 edges).
- Fill bit:
  - logical: 0.
  - arithmetic: the captured operand's bit WIDTH-1 (sign), replicated on every step.
- carry_out: the bit shifted out on the last step; 0 when amount=0.
- shifted, carry_out and zero:
  - Update on every shift step.
  - Hold their values from DONE until the next accepted start.
  - zero is combinational from shifted.
- start is ignored in SHIFT and in DONE. No queuing; a start coincident with done is dropped, and control must re-assert it.
- Operand/amount changes after capture have no effect.
- busy is 0 in IDLE and DONE.
- Reset (async, any state, including mid-shift):
  - state=IDLE, count=0.
  - shifted=0, carry_out=0, busy=0, done=0, zero=1.
  - The in-flight operation is discarded; no done pulse.
- amount wider than WIDTH is impossible with the defaults. If parameters allow amount ≥ WIDTH, the result saturates naturally: all fill bits.

Optional Feature:
- Macro SHIFTER_ROTATE_EN.
- Defined: mode=10 rotates right, with fill = the bit shifted out on that step. carry_out is the last bit rotated out. amount=WIDTH returns the operand unchanged.
- Undefined: mode=10 behaves as logical shift. No extra logic is generated.

Decomposition:
- Shared package/header:
  - mode encodings SHR_LOGICAL=2'b00, SHR_ARITH=2'b01, SHR_ROTATE=2'b10.
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
  - default WIDTH/AMT_W constants.
- One natural sub-module: shr_step, a combinational single-bit right step taking value, mode and sign, and returning the next value and the shifted-out bit. The FSM/counter stays in the top module.

Test Plan:
- Logical: start, to_shift=16'hF0F1, amount=4, mode=00 -> done 5 edges later; shifted=16'h0F0F, carry_out=0, zero=0; busy high for 4 cycles.
- Arithmetic: to_shift=16'h8001, amount=3, mode=01 -> shifted=16'hF000, carry_out=0. Repeat with amount=1 -> 16'hC000, carry_out=1.
- Zero amount: to_shift=16'h1234, amount=0 -> done after 1 edge, shifted=16'h1234, carry_out=0, busy never high. Then to_shift=16'h0001, amount=1 -> shifted=0, zero=1, carry_out=1.
- Handshake: start held high through a 15-step shift while to_shift/amount change -> only the first request is processed. Exactly one done pulse, then a new capture on the edge after done.
- Reset mid-op: assert reset_n=0 at the third SHIFT cycle -> all outputs at reset values immediately, no done. After release, a fresh request completes normally.
- With SHIFTER_ROTATE_EN: to_shift=16'h0003, amount=1, mode=10 -> shifted=16'h8001, carry_out=1. Without the macro, the same stimulus -> 16'h0001, carry_out=1.

Source files
------------

// File: rtl/serial_right_shifter_pkg.sv
// -----------------------------------------------------------------------------
// serial_right_shifter_pkg
//
// Shared definitions for the multi-cycle right shifter:
//   - default datapath width and shift-amount width
//   - shift mode encodings (logical / arithmetic / rotate)
//   - FSM state encoding used by the top-level controller
//
// Optional feature macro: SHIFTER_ROTATE_EN (consumed by shr_step; when it is
// undefined the rotate encoding decodes as a logical shift).
// -----------------------------------------------------------------------------
package serial_right_shifter_pkg;

  // Default geometry: 16-bit operand, 4-bit amount (maximum shift of 15).
  localparam int SHR_DEFAULT_WIDTH = 16;
  localparam int SHR_DEFAULT_AMT_W = 4;

  // Mode encodings. 2'b11 is unassigned and decodes as a logical shift.
  localparam logic [1:0] SHR_LOGICAL = 2'b00;
  localparam logic [1:0] SHR_ARITH   = 2'b01;
  localparam logic [1:0] SHR_ROTATE  = 2'b10;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shr_state_e;

endpackage : serial_right_shifter_pkg

// File: rtl/shr_step.sv
// -----------------------------------------------------------------------------
// shr_step
//
// Purely combinational single-bit right step of the serial shifter. The
// controller applies it once per SHIFT cycle to the working register.
//
// Ports:
//   value      in   WIDTH  current working value
//   mode       in   2      shift mode (see serial_right_shifter_pkg)
//   sign       in   1      sign bit captured with the operand (arithmetic fill)
//   next_value out  WIDTH  value shifted right by one with the selected fill
//   out_bit    out  1      bit leaving the LSB on this step
//
// Optional feature macro: SHIFTER_ROTATE_EN
//   defined   : SHR_ROTATE feeds the outgoing LSB back into the MSB.
//   undefined : SHR_ROTATE falls into the logical default; no rotate path
//               exists in the netlist.
// -----------------------------------------------------------------------------
module shr_step
  import serial_right_shifter_pkg::*;
#(
  parameter int WIDTH = SHR_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  input  logic             sign,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  logic fill;

  // NOTE: every signal written in always_comb gets a default on entry, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    fill = 1'b0;
    case (mode)
      // The sign comes from the captured operand rather than the current MSB;
      // both are equal during an arithmetic shift, but the captured copy makes
      // the replication intent explicit.
      SHR_ARITH:  fill = sign;
`ifdef SHIFTER_ROTATE_EN
      SHR_ROTATE: fill = value[0];
`endif
      default:    fill = 1'b0;
    endcase
  end

  assign out_bit    = value[0];
  assign next_value = {fill, value[WIDTH-1:1]};

endmodule : shr_step

// File: rtl/serial_right_shifter.sv
// -----------------------------------------------------------------------------
// serial_right_shifter
//
// Multi-cycle right shifter for the 16-bit datapath. A start accepted in IDLE
// captures the operand, amount and mode; the working register then moves
// right one bit per clock until the count is exhausted, and done pulses for
// one cycle. Result and flags hold from DONE until the next accepted start.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      request, sampled only in IDLE
//   to_shift   in   WIDTH  operand, captured on the accepting edge
//   amount     in   AMT_W  shift count, captured with to_shift
//   mode       in   2      00 logical, 01 arithmetic, 10 rotate, 11 logical
//   busy       out  1      high while in SHIFT
//   done       out  1      one-cycle pulse, result/flags valid
//   shifted    out  WIDTH  result register (doubles as working register)
//   carry_out  out  1      last bit shifted out (0 when amount is 0)
//   zero       out  1      shifted == 0
//
// Optional feature macro: SHIFTER_ROTATE_EN (enables mode 10 as rotate-right
// inside shr_step; otherwise mode 10 is a logical shift).
//
// Latency: the accepting edge plus one edge per shift step, so done is high
// in the cycle following amount+1 edges counted from the accepting edge.
// -----------------------------------------------------------------------------
module serial_right_shifter
  import serial_right_shifter_pkg::*;
#(
  parameter int WIDTH = SHR_DEFAULT_WIDTH,
  parameter int AMT_W = SHR_DEFAULT_AMT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] to_shift,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifted,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [AMT_W-1:0] COUNT_ONE = AMT_W'(1);

  shr_state_e       state;
  shr_state_e       state_next;
  logic [AMT_W-1:0] count;
  logic [1:0]       mode_q;
  logic             sign_q;

  logic             load;
  logic             step;
  logic [WIDTH-1:0] step_value;
  logic             step_out;

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          // A zero amount skips SHIFT entirely; the operand is the result.
          state_next = (amount != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        // count holds the steps still to perform, including this one.
        if (count == COUNT_ONE) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here: a request coincident with
        // done is dropped and must be re-asserted in IDLE.
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: single-bit step
  // ---------------------------------------------------------------------------
  shr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .value      (shifted),
    .mode       (mode_q),
    .sign       (sign_q),
    .next_value (step_value),
    .out_bit    (step_out)
  );

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset, not only the control state, because
  // shifted/carry_out are visible outputs with defined reset values and zero
  // is derived from shifted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shifted   <= '0;
      carry_out <= 1'b0;
      count     <= '0;
      mode_q    <= SHR_LOGICAL;
      sign_q    <= 1'b0;
    end else if (load) begin
      // Capture snapshot: later changes on to_shift/amount/mode are invisible
      // to the operation in flight.
      shifted   <= to_shift;
      carry_out <= 1'b0;
      count     <= amount;
      mode_q    <= mode;
      sign_q    <= to_shift[WIDTH-1];
    end else if (step) begin
      shifted   <= step_value;
      carry_out <= step_out;
      count     <= count - COUNT_ONE;
    end
  end

  assign zero = (shifted == '0);

endmodule : serial_right_shifter

// File: tb/tb_serial_right_shifter.sv
`timescale 1ns/1ps
module tb_serial_right_shifter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] to_shift;
  logic [3:0]  amount;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] shifted;
  logic        carry_out;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] shifted;
    logic        carry;
    int          edges;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_right_shifter #(
    .WIDTH (16),
    .AMT_W (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .to_shift  (to_shift),
    .amount    (amount),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .shifted   (shifted),
    .carry_out (carry_out),
    .zero      (zero)
  );

  // Reference model: {result, carry}.
  function automatic logic [16:0] model(input logic [15:0] v, input logic [3:0] amt,
                                        input logic [1:0] m);
    logic [15:0] r;
    logic        c;
    logic [31:0] dbl;
    int          idx;
    c = 1'b0;
    if (amt != 4'd0) begin
      idx = int'(amt) - 1;
      c   = v[idx];
    end
    dbl = {v, v} >> amt;
    case (m)
      2'b01:   r = $unsigned($signed(v) >>> amt);
`ifdef SHIFTER_ROTATE_EN
      2'b10:   r = dbl[15:0];
`endif
      default: r = v >> amt;
    endcase
    return {r, c};
  endfunction

  task automatic push_exp(input string name, input logic [15:0] v, input logic [3:0] amt,
                          input logic [1:0] m);
    exp_t        e;
    logic [16:0] r;
    r             = model(v, amt, m);
    e.name        = name;
    e.shifted     = r[16:1];
    e.carry       = r[0];
    e.edges       = int'(amt) + 1;
    e.busy_cycles = int'(amt);
    sb.push_back(e);
  endtask

  // Called right after the accepting edge. Waits (bounded) for done, counting
  // edges from the accepting edge and cycles with busy high. Returns at the
  // negedge where done is observed. With hold_start the request stays high and
  // the inputs are scrambled every cycle; otherwise start drops and the inputs
  // are inverted once, which must not affect the captured operation.
  task automatic wait_done(input bit hold_start, output int edges, output int busy_cycles,
                           output bit got_done);
    edges       = 1;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hold_start) begin
        to_shift = 16'($urandom);
        amount   = 4'($urandom_range(0, 15));
      end else if (i == 0) begin
        start    = 1'b0;
        to_shift = ~to_shift;
        amount   = ~amount;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] v, input logic [3:0] amt,
                        input logic [1:0] m, output int edges, output int busy_cycles,
                        output bit got_done);
    @(negedge clk);
    start    = 1'b1;
    to_shift = v;
    amount   = amt;
    mode     = m;
    push_exp(name, v, amt, m);
    @(posedge clk);
    wait_done(1'b0, edges, busy_cycles, got_done);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    to_shift = 16'h0;
    amount   = 4'd0;
    mode     = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (shifted !== 16'h0) begin errors++; $display("FAIL reset_shifted: got %h expected 0000", shifted); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
    reset_n = 1'b1;
  endtask

  task automatic test_logical();
    exp_t        e;
    int          edges, bc;
    bit          got;
    logic [15:0] held;
    run_op("logical", 16'hF0F1, 4'd4, 2'b00, edges, bc, got);
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL %s_done: got none expected pulse", e.name); end
    checks++; if (shifted !== e.shifted) begin errors++; $display("FAIL %s_shifted: got %h expected %h", e.name, shifted, e.shifted); end
    checks++; if (carry_out !== e.carry) begin errors++; $display("FAIL %s_carry: got %b expected %b", e.name, carry_out, e.carry); end
    checks++; if (zero !== (e.shifted == 16'h0)) begin errors++; $display("FAIL %s_zero: got %b expected %b", e.name, zero, e.shifted == 16'h0); end
    checks++; if (edges != e.edges) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", e.name, edges, e.edges); end
    checks++; if (bc != e.busy_cycles) begin errors++; $display("FAIL %s_busy: got %0d expected %0d", e.name, bc, e.busy_cycles); end
    // done is a single pulse and the result holds afterwards.
    held = e.shifted;
    repeat (2) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL logical_idle: got busy/done %b%b expected 00", busy, done); end
      checks++; if (shifted !== held) begin errors++; $display("FAIL logical_hold: got %h expected %h", shifted, held); end
    end
  endtask

  task automatic test_arith_zero_rotate();
    logic [15:0] vs[6] = '{16'h8001, 16'h8001, 16'h1234, 16'h0001, 16'h0003, 16'h0003};
    logic [3:0]  as[6] = '{4'd3, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1};
    logic [1:0]  ms[6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
    string       ns[6] = '{"arith3", "arith1", "amount0", "to_zero", "mode10", "mode11"};
    exp_t        e;
    int          edges, bc;
    bit          got;
    for (int i = 0; i < 6; i++) begin
      run_op(ns[i], vs[i], as[i], ms[i], edges, bc, got);
      e = sb.pop_front();
      checks++; if (!got) begin errors++; $display("FAIL %s_done: got none expected pulse", e.name); end
      checks++; if (shifted !== e.shifted) begin errors++; $display("FAIL %s_shifted: got %h expected %h", e.name, shifted, e.shifted); end
      checks++; if (carry_out !== e.carry) begin errors++; $display("FAIL %s_carry: got %b expected %b", e.name, carry_out, e.carry); end
      checks++; if (zero !== (e.shifted == 16'h0)) begin errors++; $display("FAIL %s_zero: got %b expected %b", e.name, zero, e.shifted == 16'h0); end
      checks++; if (edges != e.edges) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", e.name, edges, e.edges); end
      checks++; if (bc != e.busy_cycles) begin errors++; $display("FAIL %s_busy: got %0d expected %0d", e.name, bc, e.busy_cycles); end
    end
  endtask

  task automatic test_handshake();
    exp_t        e;
    int          edges, bc;
    bit          got;
    logic [15:0] held;
    @(negedge clk);
    start    = 1'b1;
    to_shift = 16'h9ABC;
    amount   = 4'd15;
    mode     = 2'b01;
    push_exp("hs_first", 16'h9ABC, 4'd15, 2'b01);
    @(posedge clk);
    wait_done(1'b1, edges, bc, got);
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL %s_done: got none expected pulse", e.name); end
    checks++; if (shifted !== e.shifted) begin errors++; $display("FAIL %s_shifted: got %h expected %h", e.name, shifted, e.shifted); end
    checks++; if (carry_out !== e.carry) begin errors++; $display("FAIL %s_carry: got %b expected %b", e.name, carry_out, e.carry); end
    checks++; if (edges != e.edges) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", e.name, edges, e.edges); end
    checks++; if (bc != e.busy_cycles) begin errors++; $display("FAIL %s_busy: got %0d expected %0d", e.name, bc, e.busy_cycles); end
    held = e.shifted;
    // start stays high through DONE; this request must only be taken in IDLE.
    to_shift = 16'h0F00;
    amount   = 4'd2;
    mode     = 2'b00;
    push_exp("hs_second", 16'h0F00, 4'd2, 2'b00);
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL hs_drop_in_done: got busy/done %b%b expected 00", busy, done); end
    checks++; if (shifted !== held) begin errors++; $display("FAIL hs_hold: got %h expected %h", shifted, held); end
    @(posedge clk);
    wait_done(1'b0, edges, bc, got);
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL %s_done: got none expected pulse", e.name); end
    checks++; if (shifted !== e.shifted) begin errors++; $display("FAIL %s_shifted: got %h expected %h", e.name, shifted, e.shifted); end
    checks++; if (edges != e.edges) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", e.name, edges, e.edges); end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int   edges, bc;
    bit   got;
    int   done_seen;
    @(negedge clk);
    start    = 1'b1;
    to_shift = 16'hABCD;
    amount   = 4'd10;
    mode     = 2'b01;
    push_exp("discarded", 16'hABCD, 4'd10, 2'b01);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    sb.delete();
    #1;
    checks++; if (shifted !== 16'h0 || carry_out !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got %h/%b expected 0000/0", shifted, carry_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL rst_mid_flags: got busy/done/zero %b%b%b expected 001", busy, done, zero); end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_seen); end
    run_op("after_reset", 16'h00F0, 4'd4, 2'b00, edges, bc, got);
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL %s_done: got none expected pulse", e.name); end
    checks++; if (shifted !== e.shifted) begin errors++; $display("FAIL %s_shifted: got %h expected %h", e.name, shifted, e.shifted); end
    checks++; if (edges != e.edges) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", e.name, edges, e.edges); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          edges, bc;
    bit          got;
    logic [15:0] v;
    logic [3:0]  a;
    logic [1:0]  m;
    for (int i = 0; i < 24; i++) begin
      v = 16'($urandom);
      a = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), v, a, m, edges, bc, got);
      e = sb.pop_front();
      checks++; if (!got) begin errors++; $display("FAIL %s_done: got none expected pulse", e.name); end
      checks++; if (shifted !== e.shifted || carry_out !== e.carry) begin errors++; $display("FAIL %s_result: got %h/%b expected %h/%b", e.name, shifted, carry_out, e.shifted, e.carry); end
      checks++; if (zero !== (e.shifted == 16'h0)) begin errors++; $display("FAIL %s_zero: got %b expected %b", e.name, zero, e.shifted == 16'h0); end
      checks++; if (edges != e.edges || bc != e.busy_cycles) begin errors++; $display("FAIL %s_timing: got %0d/%0d expected %0d/%0d", e.name, edges, bc, e.edges, e.busy_cycles); end
    end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith_zero_rotate();
    test_handshake();
    test_reset_mid_op();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_right_shifter
